vga_timing_gen: RTL and testbench

- Pixel-timing back end that sits directly downstream of the scene/colour generator logic.
- Runs H/V counters and publishes the current pixel coordinate and a data request to the host.
- Registers host colour onto the DAC bus, pipeline-aligned with HS/VS/BLANK.
- Drives the ADV-style VGA DAC pins (clock, sync, blank) at 25 MHz pixel rate; the host supplies iCLK = 50 MHz/2.

---
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA pixel-timing back end for an ADV-style video DAC.
//
// Runs free-running horizontal/vertical counters at the pixel rate, publishes
// the current active-region coordinate and a colour request to the host, and
// registers the host colour onto the DAC bus together with HS/VS/BLANK so all
// DAC-side signals share the same one-cycle latency.
//
// Optional build macro: VGA_TEST_PATTERN_EN
//   Adds iTestMode; when high, the colour is replaced by 8 vertical colour bars.
//
// Ports:
//   iCLK                 pixel clock
//   iRST_N               synchronous active-low reset
//   iRed/iGreen/iBlue    host colour for the pixel at oCurrent_X/Y
//   iTestMode            colour-bar override (VGA_TEST_PATTERN_EN only)
//   oCurrent_X/Y         active-region coordinate, 0 outside active
//   oRequest             high while the counters are in the active region
//   oFrameStart          one-cycle pulse at counter origin (0,0)
//   oVGA_R/G/B           registered colour to DAC
//   oVGA_HS/VS           negative-polarity syncs (registered)
//   oVGA_BLANK           active-low blank, 1 = visible (registered)
//   oVGA_SYNC            constant 0, sync-on-green unused
//   oVGA_CLOCK           inverted pixel clock, DAC latches mid-cycle
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int COLOR_W  = 10
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               iTestMode,
`endif
    output logic [10:0]        oCurrent_X,
    output logic [10:0]        oCurrent_Y,
    output logic               oRequest,
    output logic               oFrameStart,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLOCK
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] LP_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] LP_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] LP_H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] LP_V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] LP_HS_BEG   = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] LP_HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] LP_VS_BEG   = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] LP_VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [10:0]        r_h_cnt;
    logic [10:0]        r_v_cnt;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;
    logic               r_hs;
    logic               r_vs;
    logic               r_blank;

    logic               w_in_active;
    logic               w_active;
    logic               w_in_hsync;
    logic               w_in_vsync;
    logic [COLOR_W-1:0] w_red;
    logic [COLOR_W-1:0] w_green;
    logic [COLOR_W-1:0] w_blue;

    // Counters: h wraps at the end of the line, v advances only on the h wrap.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == LP_H_LAST) begin
            r_h_cnt <= '0;
            if (r_v_cnt == LP_V_LAST) begin
                r_v_cnt <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + 11'd1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    assign w_in_active = (r_h_cnt < LP_H_ACT) && (r_v_cnt < LP_V_ACT);
    assign w_in_hsync  = (r_h_cnt >= LP_HS_BEG) && (r_h_cnt < LP_HS_END);
    assign w_in_vsync  = (r_v_cnt >= LP_VS_BEG) && (r_v_cnt < LP_VS_END);

    // Stage-0 outputs are gated by reset so the host sees no request while held.
    assign w_active    = iRST_N && w_in_active;
    assign oCurrent_X  = w_active ? r_h_cnt : '0;
    assign oCurrent_Y  = w_active ? r_v_cnt : '0;
    assign oRequest    = w_active;
    assign oFrameStart = iRST_N && (r_h_cnt == '0) && (r_v_cnt == '0);

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [10:0] LP_BAR_W = 11'(H_ACTIVE / 8);
    logic [2:0] w_bar;
    assign w_bar = 3'(r_h_cnt / LP_BAR_W);
`endif

    // Colour select; anything outside the active region goes to black.
    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        if (w_in_active) begin
            w_red   = iRed;
            w_green = iGreen;
            w_blue  = iBlue;
`ifdef VGA_TEST_PATTERN_EN
            if (iTestMode) begin
                w_red   = {COLOR_W{w_bar[2]}};
                w_green = {COLOR_W{w_bar[1]}};
                w_blue  = {COLOR_W{w_bar[0]}};
            end
`endif
        end
    end

    // Stage 1: every DAC-side signal is registered here for common latency.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_blank <= 1'b0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
        end else begin
            r_red   <= w_red;
            r_green <= w_green;
            r_blue  <= w_blue;
            r_blank <= w_in_active;
            r_hs    <= ~w_in_hsync;
            r_vs    <= ~w_in_vsync;
        end
    end

    assign oVGA_R     = r_red;
    assign oVGA_G     = r_green;
    assign oVGA_B     = r_blue;
    assign oVGA_BLANK = r_blank;
    assign oVGA_HS    = r_hs;
    assign oVGA_VS    = r_vs;
    assign oVGA_SYNC  = 1'b0;
    assign oVGA_CLOCK = ~iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default-timing instance (index 0) and a
// shrunken-timing instance (index 1, so whole frames fit in a short run) are
// checked every cycle against a position-based model, plus literal checks.
module tb_vga_timing_gen;

    localparam int S_HA = 32, S_HF = 4, S_HS = 8, S_HB = 6;
    localparam int S_VA = 20, S_VF = 3, S_VS = 2, S_VB = 5;

    int HA[2] = '{640, S_HA};
    int HF[2] = '{16,  S_HF};
    int HS[2] = '{96,  S_HS};
    int HB[2] = '{48,  S_HB};
    int VA[2] = '{480, S_VA};
    int VF[2] = '{10,  S_VF};
    int VS[2] = '{2,   S_VS};
    int VB[2] = '{33,  S_VB};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tm = 1'b0;
    logic [9:0] i_red = '0;
    logic [9:0] i_green = '0;
    logic [9:0] i_blue = '0;

    logic [10:0] o_x[2];
    logic [10:0] o_y[2];
    logic        o_req[2];
    logic        o_fs[2];
    logic [9:0]  o_r[2];
    logic [9:0]  o_g[2];
    logic [9:0]  o_b[2];
    logic        o_hs[2];
    logic        o_vs[2];
    logic        o_blank[2];
    logic        o_sync[2];
    logic        o_dclk[2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_def (
        .iCLK(clk), .iRST_N(rst_n),
        .iRed(i_red), .iGreen(i_green), .iBlue(i_blue),
`ifdef VGA_TEST_PATTERN_EN
        .iTestMode(tm),
`endif
        .oCurrent_X(o_x[0]), .oCurrent_Y(o_y[0]),
        .oRequest(o_req[0]), .oFrameStart(o_fs[0]),
        .oVGA_R(o_r[0]), .oVGA_G(o_g[0]), .oVGA_B(o_b[0]),
        .oVGA_HS(o_hs[0]), .oVGA_VS(o_vs[0]), .oVGA_BLANK(o_blank[0]),
        .oVGA_SYNC(o_sync[0]), .oVGA_CLOCK(o_dclk[0])
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .COLOR_W(10)
    ) u_dut_small (
        .iCLK(clk), .iRST_N(rst_n),
        .iRed(i_red), .iGreen(i_green), .iBlue(i_blue),
`ifdef VGA_TEST_PATTERN_EN
        .iTestMode(tm),
`endif
        .oCurrent_X(o_x[1]), .oCurrent_Y(o_y[1]),
        .oRequest(o_req[1]), .oFrameStart(o_fs[1]),
        .oVGA_R(o_r[1]), .oVGA_G(o_g[1]), .oVGA_B(o_b[1]),
        .oVGA_HS(o_hs[1]), .oVGA_VS(o_vs[1]), .oVGA_BLANK(o_blank[1]),
        .oVGA_SYNC(o_sync[1]), .oVGA_CLOCK(o_dclk[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each instance is a linear position within the frame; the
    // expected registered outputs are derived from the position at each edge.
    int         m_pos[2];
    bit         m_valid = 1'b0;
    logic [9:0] e_r[2], e_g[2], e_b[2];
    logic       e_blank[2], e_hs[2], e_vs[2];

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int htot, vtot, h, v, bar;
            bit act;
            htot = HA[k] + HF[k] + HS[k] + HB[k];
            vtot = VA[k] + VF[k] + VS[k] + VB[k];
            h = m_pos[k] % htot;
            v = m_pos[k] / htot;
            if (!rst_n) begin
                m_pos[k] = 0;
                e_r[k] = '0; e_g[k] = '0; e_b[k] = '0;
                e_blank[k] = 1'b0; e_hs[k] = 1'b1; e_vs[k] = 1'b1;
            end else if (m_valid) begin
                act = (h < HA[k]) && (v < VA[k]);
                e_blank[k] = act;
                e_hs[k] = !((h >= HA[k] + HF[k]) && (h < HA[k] + HF[k] + HS[k]));
                e_vs[k] = !((v >= VA[k] + VF[k]) && (v < VA[k] + VF[k] + VS[k]));
                if (!act) begin
                    e_r[k] = '0; e_g[k] = '0; e_b[k] = '0;
                end else if (tm) begin
                    bar = h / (HA[k] / 8);
                    e_r[k] = (bar & 4) != 0 ? 10'h3FF : 10'h000;
                    e_g[k] = (bar & 2) != 0 ? 10'h3FF : 10'h000;
                    e_b[k] = (bar & 1) != 0 ? 10'h3FF : 10'h000;
                end else begin
                    e_r[k] = i_red; e_g[k] = i_green; e_b[k] = i_blue;
                end
                m_pos[k] = (m_pos[k] + 1) % (htot * vtot);
            end
        end
        if (!rst_n) m_valid = 1'b1;
    end

    // Host colour: red follows the default instance's X, 3FF outside active.
    initial forever begin
        int h0, v0;
        @(posedge clk);
        #3;
        h0 = m_pos[0] % 800;
        v0 = m_pos[0] / 800;
        i_red   = (h0 < 640 && v0 < 480) ? 10'(h0) : 10'h3FF;
        i_green = 10'($urandom);
        i_blue  = ~i_red;
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                int htot, h, v;
                bit act;
                htot = HA[k] + HF[k] + HS[k] + HB[k];
                h = m_pos[k] % htot;
                v = m_pos[k] / htot;
                act = rst_n && (h < HA[k]) && (v < VA[k]);
                chk($sformatf("x[%0d]", k),     32'(o_x[k]),     act ? 32'(h) : 32'd0);
                chk($sformatf("y[%0d]", k),     32'(o_y[k]),     act ? 32'(v) : 32'd0);
                chk($sformatf("req[%0d]", k),   32'(o_req[k]),   32'(act));
                chk($sformatf("fs[%0d]", k),    32'(o_fs[k]),    32'(rst_n && m_pos[k] == 0));
                chk($sformatf("r[%0d]", k),     32'(o_r[k]),     32'(e_r[k]));
                chk($sformatf("g[%0d]", k),     32'(o_g[k]),     32'(e_g[k]));
                chk($sformatf("b[%0d]", k),     32'(o_b[k]),     32'(e_b[k]));
                chk($sformatf("blank[%0d]", k), 32'(o_blank[k]), 32'(e_blank[k]));
                chk($sformatf("hs[%0d]", k),    32'(o_hs[k]),    32'(e_hs[k]));
                chk($sformatf("vs[%0d]", k),    32'(o_vs[k]),    32'(e_vs[k]));
                chk($sformatf("sync[%0d]", k),  32'(o_sync[k]),  32'd0);
                chk($sformatf("dclk[%0d]", k),  32'(o_dclk[k]),  32'd1);
            end
        end
    end

    // Directed sequence with literal expectations.
    initial begin
        int req_cnt = 0, hs_cnt = 0, hs_first = -1;
        int vs_cnt = 0, vs_first = -1, fs1_cnt = 0;

        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_hs",    32'(o_hs[0]),    32'd1);
        chk("rst_vs",    32'(o_vs[0]),    32'd1);
        chk("rst_blank", 32'(o_blank[0]), 32'd0);
        chk("rst_r",     32'(o_r[0]),     32'd0);
        chk("rst_req",   32'(o_req[0]),   32'd0);
        chk("rst_fs",    32'(o_fs[0]),    32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);

        for (int c = 0; c < 4200; c++) begin
            if (c == 0) begin
                chk("first_x",   32'(o_x[0]),   32'd0);
                chk("first_y",   32'(o_y[0]),   32'd0);
                chk("first_req", 32'(o_req[0]), 32'd1);
                chk("first_fs",  32'(o_fs[0]),  32'd1);
            end
            if (c < 800) begin
                if (o_req[0] === 1'b1) req_cnt++;
                if (o_hs[0] === 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = c;
                end
            end
            if (c == 800) begin
                chk("line_req_cnt", 32'(req_cnt),  32'd640);
                chk("line_hs_cnt",  32'(hs_cnt),   32'd96);
                chk("line_hs_first", 32'(hs_first), 32'd657);
                chk("line2_x",   32'(o_x[0]),   32'd0);
                chk("line2_y",   32'(o_y[0]),   32'd1);
                chk("line2_req", 32'(o_req[0]), 32'd1);
            end
            if (c == 101) chk("r_prev_x", 32'(o_r[0]), 32'd100);
            if (c == 641) begin
                chk("blank_off", 32'(o_blank[0]), 32'd0);
                chk("r_blank0",  32'(o_r[0]),     32'd0);
            end
            if (c < 1500) begin
                if (o_vs[1] === 1'b0) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = c;
                end
            end
            if (c < 3200 && o_fs[1] === 1'b1) fs1_cnt++;
            if (c == 1500) begin
                chk("frame_fs",   32'(o_fs[1]),  32'd1);
                chk("vs_cnt",     32'(vs_cnt),   32'd100);
                chk("vs_first",   32'(vs_first), 32'd1151);
            end
            if (c == 1499) chk("frame_fs_before", 32'(o_fs[1]), 32'd0);
            if (c == 3200) chk("fs_count", 32'(fs1_cnt), 32'd3);
            if (c == 3500) begin
                chk("pre_rst_x", 32'(o_x[0]), 32'd300);
                chk("pre_rst_y", 32'(o_y[0]), 32'd4);
            end
            if (c == 3501) begin
                chk("in_rst_req", 32'(o_req[0]), 32'd0);
                chk("in_rst_x",   32'(o_x[0]),   32'd0);
            end
            if (c == 3502) begin
                chk("post_rst_x",     32'(o_x[0]),     32'd0);
                chk("post_rst_y",     32'(o_y[0]),     32'd0);
                chk("post_rst_fs",    32'(o_fs[0]),    32'd1);
                chk("post_rst_req",   32'(o_req[0]),   32'd1);
                chk("post_rst_blank", 32'(o_blank[0]), 32'd0);
                chk("post_rst_hs",    32'(o_hs[0]),    32'd1);
            end
`ifdef VGA_TEST_PATTERN_EN
            if (c == 3503) begin
                chk("bar0_r", 32'(o_r[0]), 32'h000);
                chk("bar0_g", 32'(o_g[0]), 32'h000);
                chk("bar0_b", 32'(o_b[0]), 32'h000);
            end
            if (c == 3583) begin
                chk("bar1_r", 32'(o_r[0]), 32'h000);
                chk("bar1_g", 32'(o_g[0]), 32'h000);
                chk("bar1_b", 32'(o_b[0]), 32'h3FF);
            end
            if (c == 4063 || c == 4142) begin
                chk("bar7_r", 32'(o_r[0]), 32'h3FF);
                chk("bar7_g", 32'(o_g[0]), 32'h3FF);
                chk("bar7_b", 32'(o_b[0]), 32'h3FF);
            end
`endif
            @(posedge clk);
            #2;
            rst_n = (c + 1 != 3501);
`ifdef VGA_TEST_PATTERN_EN
            tm = (c + 1 >= 3502);
`endif
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
